// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART receiver and transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_state_t;

    localparam int DATA_BITS = 8;

    // Clocks per oversampling tick, rounded down.
    function automatic int baud_div(input int clk_freq, input int baud, input int oversample);
        return clk_freq / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider producing a one-clk tick every DIV clocks.
// Latency: first tick DIV clocks after clr drops; clr forces the phase back to zero.
// Backpressure: none -- tick is a strobe, the consumer must act on it in that cycle.
module uart_baud_tick #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // count 0..DIV-1 and wrap; clr pins the count at zero so the next tick is a full period away
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with 2-flop synchroniser, start-bit check and 3-sample majority vote per bit.
// Latency: rx reaches decisions 2 clk late; data_valid pulses 1 clk after the mid-stop-bit vote.
// Backpressure: none -- data_valid/frame_err are single-cycle strobes; data_out holds until the next good frame.
// Build option UART_RX_PARITY_EN adds a parity bit before the stop bit, PARITY_ODD and the parity_err strobe.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);

    localparam int DIV = baud_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int M   = OVERSAMPLE / 2;
    localparam int TW  = $clog2(OVERSAMPLE);

    // vote window is the three ticks around mid-bit; T_HI is where the decision is taken
    localparam logic [TW-1:0] T_LO  = TW'(M - 1);
    localparam logic [TW-1:0] T_MID = TW'(M);
    localparam logic [TW-1:0] T_HI  = TW'(M + 1);
    localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

    logic                 rx_meta;
    logic                 rx_s;
    logic                 rx_d;
    logic                 tick;
    logic                 tick_clr;
    logic [TW-1:0]        t;
    logic [1:0]           ones;
    logic                 maj;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    uart_state_t          state;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit;
`endif

    // two-flop synchroniser plus one delay flop for falling-edge detection; idle line is high
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    // divider is held in IDLE so the tick phase is referenced to the start edge
    assign tick_clr = (state == IDLE);

    uart_baud_tick #(
        .DIV(DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .clr (tick_clr),
        .tick(tick)
    );

    // ones holds the count of high samples at T_LO and T_MID (0..2); rx_s supplies the third vote
    assign maj = ones[1] | (ones[0] & rx_s);

    // receive FSM: tick-indexed sampling, bit assembly and registered result strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            t          <= '0;
            ones       <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    t       <= '0;
                    ones    <= '0;
                    bit_cnt <= '0;
                    if (rx_d && !rx_s) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                BREAK: begin
                    // a held-low line must go high before another start edge is accepted
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    if (tick) begin
                        t <= (t == T_END) ? '0 : t + 1'b1;
                        if (t == T_LO || t == T_MID) begin
                            ones <= ones + {1'b0, rx_s};
                        end else if (t == T_HI) begin
                            ones <= '0;
                        end
                        case (state)
                            START: begin
                                if (t == T_HI && maj) begin
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                end else if (t == T_END) begin
                                    state <= DATA;
                                end
                            end
                            DATA: begin
                                if (t == T_HI) begin
                                    shreg <= {maj, shreg[DATA_BITS-1:1]};
                                end
                                if (t == T_END) begin
                                    bit_cnt <= bit_cnt + 3'd1;
                                    if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                                        state <= PARITY;
`else
                                        state <= STOP;
`endif
                                    end
                                end
                            end
`ifdef UART_RX_PARITY_EN
                            PARITY: begin
                                if (t == T_HI) begin
                                    par_bit <= maj;
                                end
                                if (t == T_END) begin
                                    state <= STOP;
                                end
                            end
`endif
                            STOP: begin
                                // leave mid-stop so a back-to-back start edge is not missed
                                if (t == T_HI) begin
                                    if (maj) begin
                                        state <= IDLE;
                                        busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                                        if (par_bit != ((^shreg) ^ PARITY_ODD)) begin
                                            parity_err <= 1'b1;
                                        end else begin
                                            data_out   <= shreg;
                                            data_valid <= 1'b1;
                                        end
`else
                                        data_out   <= shreg;
                                        data_valid <= 1'b1;
`endif
                                    end else begin
                                        frame_err <= 1'b1;
                                        state     <= BREAK;
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomised frames against a frame-level event model.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_rx;

    localparam int CLK_FREQ = 1600000;
    localparam int BAUD     = 10000;
    localparam int OS       = 16;
    localparam int BIT      = (CLK_FREQ / (BAUD * OS)) * OS;   // clocks per bit = 160
    localparam bit PODD     = 1'b0;
`ifdef UART_RX_PARITY_EN
    localparam bit HAS_PAR  = 1'b1;
`else
    localparam bit HAS_PAR  = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    // events: [9:8] = 1 good byte, 2 frame error, 3 parity error; [7:0] = byte
    logic [9:0] got_q[$];
    logic [9:0] exp_q[$];
    logic [7:0] last;

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    uart_rx #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD(BAUD),
        .OVERSAMPLE(OS)
`ifdef UART_RX_PARITY_EN
        ,
        .PARITY_ODD(PODD)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .data_out(data_out),
        .data_valid(data_valid),
        .frame_err(frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // record every strobe; at most one strobe may fire per cycle
    always @(negedge clk) begin
        if (data_valid || frame_err || parity_err) begin
            chk("one_strobe", int'(data_valid) + int'(frame_err) + int'(parity_err), 1);
            if (data_valid) got_q.push_back({2'b01, data_out});
            if (frame_err)  got_q.push_back({2'b10, 8'h00});
            if (parity_err) got_q.push_back({2'b11, 8'h00});
        end
    end

    function automatic logic good_par(input logic [7:0] d);
        return (^d) ^ PODD;
    endfunction

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    // frame-level model: outcome depends only on stop bit and parity agreement
    task automatic expect_frame(input logic [7:0] d, input logic stop, input logic par);
        if (!stop) begin
            exp_q.push_back({2'b10, 8'h00});
        end else if (HAS_PAR && par != good_par(d)) begin
            exp_q.push_back({2'b11, 8'h00});
        end else begin
            exp_q.push_back({2'b01, d});
            last = d;
        end
    endtask

    // drive one frame; rst_bit >= 0 pulses rst for one clk in the middle of that data bit
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par, input int rst_bit);
        rx = 1'b0;
        hold(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            if (i == rst_bit) begin
                hold(BIT / 2);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("rst_dout", data_out, 8'h00);
                chk("rst_busy", busy, 1'b0);
                chk("rst_strobes", {data_valid, frame_err, parity_err}, 3'b000);
                hold(BIT - BIT / 2 - 1);
            end else begin
                hold(BIT);
            end
        end
        if (HAS_PAR) begin
            rx = par;
            hold(BIT);
        end
        rx = stop;
        hold(BIT);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 20 * BIT) begin
            @(negedge clk);
            n++;
        end
        chk(tag, busy, 1'b0);
    endtask

    task automatic drain(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk(tag, got_q[i], exp_q[i]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rst  = 1'b1;
        rx   = 1'b1;
        last = 8'h00;
        hold(5);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_dout", data_out, 8'h00);
        chk("reset_valid", data_valid, 1'b0);
        chk("reset_ferr", frame_err, 1'b0);
        chk("reset_busy", busy, 1'b0);
        hold(BIT);

        // plain frame
        expect_frame(8'h55, 1'b1, good_par(8'h55));
        send_frame(8'h55, 1'b1, good_par(8'h55), -1);
        hold(BIT);
        wait_idle("idle_55");
        drain("frame_55");
        chk("dout_55", data_out, 8'h55);

        // short low glitch must be rejected as a false start
        rx = 1'b0;
        hold(40);
        rx = 1'b1;
        hold(2 * BIT);
        drain("glitch");
        chk("dout_glitch", data_out, last);
        chk("busy_glitch", busy, 1'b0);

        // bad stop bit followed by a held-low line: one frame_err, busy until the line recovers
        expect_frame(8'hA5, 1'b0, good_par(8'hA5));
        send_frame(8'hA5, 1'b0, good_par(8'hA5), -1);
        hold(3 * BIT);
        chk("busy_break", busy, 1'b1);
        rx = 1'b1;
        wait_idle("idle_break");
        hold(BIT);
        drain("ferr");
        chk("dout_ferr", data_out, last);

        // back-to-back frames with no idle gap
        expect_frame(8'hA5, 1'b1, good_par(8'hA5));
        expect_frame(8'h3C, 1'b1, good_par(8'h3C));
        send_frame(8'hA5, 1'b1, good_par(8'hA5), -1);
        send_frame(8'h3C, 1'b1, good_par(8'h3C), -1);
        hold(BIT);
        drain("b2b");

        // reset during data bit 4; upper bits are 1 so the rest of the frame has no falling edge
        send_frame(8'hF1, 1'b1, good_par(8'hF1), 4);
        last = 8'h00;
        hold(BIT);
        drain("rst_frame");
        chk("dout_after_rst", data_out, 8'h00);
        expect_frame(8'h81, 1'b1, good_par(8'h81));
        send_frame(8'h81, 1'b1, good_par(8'h81), -1);
        hold(BIT);
        drain("frame_81");
        chk("dout_81", data_out, 8'h81);

        if (HAS_PAR) begin
            expect_frame(8'h07, 1'b1, 1'b0);
            send_frame(8'h07, 1'b1, 1'b0, -1);
            hold(BIT);
            expect_frame(8'h07, 1'b1, 1'b1);
            send_frame(8'h07, 1'b1, 1'b1, -1);
            hold(BIT);
            drain("parity");
            chk("dout_parity", data_out, 8'h07);
        end

        // randomised traffic: random bytes, occasional bad stop / parity, random gaps
        for (int k = 0; k < 16; k++) begin
            logic [7:0] d;
            logic       st;
            logic       p;
            d  = 8'($urandom);
            st = ($urandom_range(0, 5) != 0);
            p  = good_par(d) ^ ($urandom_range(0, 4) == 0);
            expect_frame(d, st, p);
            send_frame(d, st, p, -1);
            if (!st) begin
                hold($urandom_range(0, BIT));
                rx = 1'b1;
                hold(BIT / 4);
            end
            hold($urandom_range(0, BIT));
        end
        rx = 1'b1;
        hold(BIT);
        wait_idle("idle_rand");
        drain("random");
        chk("dout_rand", data_out, last);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
